// File: rtl/dual_issue_fetch_buffer_pkg.sv
// Shared types for the dual-issue fetch buffer: instruction word, fetch entry and dequeue count.
package dual_issue_fetch_buffer_pkg;

  localparam int pc_width_gp    = 22;
  localparam int instr_width_gp = 32;

  typedef logic [instr_width_gp-1:0] instruction_s;

  typedef enum logic [1:0] {
    DEQ_NONE = 2'd0,
    DEQ_ONE  = 2'd1,
    DEQ_TWO  = 2'd2
  } fetch_deq_e;

  typedef struct packed {
    instruction_s           instr;
    logic [pc_width_gp-1:0] pc;
  } fetch_entry_s;

  // Decode may ask for more than is issuable; only what is actually valid is retired.
  function automatic fetch_deq_e clamp_deq(input logic [1:0] req, input fetch_deq_e avail);
    return (req > avail) ? avail : fetch_deq_e'(req);
  endfunction

endpackage

// File: rtl/dual_issue_fetch_buffer_rf.sv
// Fetch-entry storage: one write port, two asynchronous read ports (slot0 and slot1).
// Contents are intentionally not reset; the top masks unused slots.
module dual_issue_fetch_buffer_rf
  import dual_issue_fetch_buffer_pkg::*;
#(
  parameter int els_p = 4,
  localparam int ptr_w = $clog2(els_p)
) (
  input  logic             clk_i,
  input  logic             w_v_i,
  input  logic [ptr_w-1:0] w_addr_i,
  input  fetch_entry_s     w_data_i,
  input  logic [ptr_w-1:0] r0_addr_i,
  input  logic [ptr_w-1:0] r1_addr_i,
  output fetch_entry_s     r0_data_o,
  output fetch_entry_s     r1_data_o
);

  fetch_entry_s mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign r0_data_o = mem_q[r0_addr_i];
  assign r1_data_o = mem_q[r1_addr_i];

endmodule

// File: rtl/dual_issue_fetch_buffer.sv
// Instruction queue feeding dual-issue decode; presents the two oldest entries as an issue pair.
// Optional same-cycle empty-buffer bypass enabled by defining DUAL_ISSUE_FETCH_BUFFER_BYPASS_EN.
module dual_issue_fetch_buffer
  import dual_issue_fetch_buffer_pkg::*;
#(
  parameter int els_p      = 4,
  parameter int pc_width_p = 22
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [31:0]                instr_i,
  input  logic [pc_width_p-1:0]      pc_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  output logic [1:0]                 v_o,
  output logic [1:0][31:0]           instr_o,
  output logic [1:0][pc_width_p-1:0] pc_o,
  input  logic [1:0]                 deq_cnt_i
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_p1;
  logic [cnt_w-1:0] count_q, count_d;
  fetch_entry_s     w_data, r0_data, r1_data, slot0;
  logic             stored_v0, stored_v1, slot_v0, bypass, enq, byp_taken, we;
  fetch_deq_e       avail, deq_n;

  assign rd_ptr_p1   = rd_ptr_q + ptr_w'(1);
  assign w_data.instr = instr_i;
  assign w_data.pc    = pc_i;

  dual_issue_fetch_buffer_rf #(.els_p(els_p)) rf (
    .clk_i     (clk_i),
    .w_v_i     (we),
    .w_addr_i  (wr_ptr_q),
    .w_data_i  (w_data),
    .r0_addr_i (rd_ptr_q),
    .r1_addr_i (rd_ptr_p1),
    .r0_data_o (r0_data),
    .r1_data_o (r1_data)
  );

  assign ready_o   = (count_q != cnt_w'(els_p));
  assign stored_v0 = (count_q != '0);
  // A taken-branch target behind slot0 is not sequential, so it must issue alone.
  assign stored_v1 = (count_q >= cnt_w'(2)) && (r1_data.pc == r0_data.pc + pc_width_gp'(1));

`ifdef DUAL_ISSUE_FETCH_BUFFER_BYPASS_EN
  assign bypass = (count_q == '0) & v_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign slot_v0   = stored_v0 | bypass;
  assign slot0     = bypass ? w_data : r0_data;
  assign avail     = stored_v1 ? DEQ_TWO : (slot_v0 ? DEQ_ONE : DEQ_NONE);
  assign deq_n     = clamp_deq(deq_cnt_i, avail);
  assign enq       = v_i & ready_o;
  assign byp_taken = bypass & (deq_n != DEQ_NONE);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (!byp_taken) begin
      we       = enq;
      wr_ptr_d = wr_ptr_q + ptr_w'(enq);
      rd_ptr_d = rd_ptr_q + ptr_w'(deq_n);
      count_d  = count_q + cnt_w'(enq) - cnt_w'(deq_n);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    v_o     = {stored_v1, slot_v0};
    instr_o = '0;
    pc_o    = '0;
    if (slot_v0) begin
      instr_o[0] = slot0.instr;
      pc_o[0]    = slot0.pc;
    end
    if (stored_v1) begin
      instr_o[1] = r1_data.instr;
      pc_o[1]    = r1_data.pc;
    end
  end

  assert property (@(posedge clk_i) disable iff (reset_i) deq_cnt_i <= avail);
  // A held fetch against a queue that decode is draining is ordinary back-pressure;
  // only a stalled full queue with v_i high loses an entry.
  assert property (@(posedge clk_i) disable iff (reset_i)
    !(v_i && !ready_o && deq_cnt_i == 2'd0 && !flush_i));

endmodule

// File: tb/tb_dual_issue_fetch_buffer.sv
// Scoreboard bench for dual_issue_fetch_buffer; builds with or without DUAL_ISSUE_FETCH_BUFFER_BYPASS_EN.
module tb_dual_issue_fetch_buffer;
  import dual_issue_fetch_buffer_pkg::*;

  localparam int els_lp = 4;
  localparam int pcw_lp = 22;
`ifdef DUAL_ISSUE_FETCH_BUFFER_BYPASS_EN
  localparam bit byp_lp = 1'b1;
`else
  localparam bit byp_lp = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   reset_i, v_i, flush_i, ready_o;
  logic [31:0]            instr_i;
  logic [pcw_lp-1:0]      pc_i;
  logic [1:0]             v_o, deq_cnt_i;
  logic [1:0][31:0]       instr_o;
  logic [1:0][pcw_lp-1:0] pc_o;

  dual_issue_fetch_buffer #(.els_p(els_lp), .pc_width_p(pcw_lp)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .v_i       (v_i),
    .instr_i   (instr_i),
    .pc_i      (pc_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .v_o       (v_o),
    .instr_o   (instr_o),
    .pc_o      (pc_o),
    .deq_cnt_i (deq_cnt_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [pcw_lp-1:0] pc; logic [31:0] instr; } ent_t;
  typedef struct packed { logic v; logic [pcw_lp-1:0] pc; logic [1:0] deq; logic fl; } stim_t;

  ent_t  sb[$];
  stim_t stim_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [31:0] mk_instr(input logic [pcw_lp-1:0] pc);
    return {10'h2b3, pc} ^ 32'h0005_a5a5;
  endfunction

  task automatic add(input logic v, input logic [pcw_lp-1:0] pc, input logic [1:0] deq, input logic fl);
    stim_t c;
    c.v = v; c.pc = pc; c.deq = deq; c.fl = fl;
    stim_q.push_back(c);
  endtask

  // Expected outputs for this cycle's inputs, from the reference queue.
  task automatic model_expect(input stim_t c, output logic [1:0] ev, output ent_t e0,
                              output ent_t e1, output logic er);
    e0 = '0; e1 = '0; ev = 2'b00;
    er = (sb.size() != els_lp);
    if (byp_lp && sb.size() == 0 && c.v && !c.fl) begin
      ev = 2'b01;
      e0.pc = c.pc;
      e0.instr = mk_instr(c.pc);
    end else begin
      if (sb.size() >= 1) begin
        ev[0] = 1'b1;
        e0 = sb[0];
      end
      if (sb.size() >= 2) begin
        if (sb[1].pc == sb[0].pc + 22'd1) begin
          ev[1] = 1'b1;
          e1 = sb[1];
        end
      end
    end
  endtask

  task automatic drive(input stim_t c);
    v_i = c.v; pc_i = c.pc; instr_i = mk_instr(c.pc); deq_cnt_i = c.deq; flush_i = c.fl;
  endtask

  task automatic advance(input stim_t c);
    bit acc;
    @(posedge clk_i);
    acc = c.v && (sb.size() != els_lp);
    if (c.fl) sb.delete();
    else if (byp_lp && sb.size() == 0 && c.v && c.deq != 2'd0) acc = 1'b0;
    else begin
      for (int k = 0; k < int'(c.deq); k++) void'(sb.pop_front());
      if (acc) sb.push_back({c.pc, mk_instr(c.pc)});
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t c;
    c = '0;
    drive(c);
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (v_o !== 2'b00) begin n_bad++; $display("FAIL reset[%0d] v_o: got %b want 00", i, v_o); end
      n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset[%0d] ready_o: got %b want 1", i, ready_o); end
      n_cmp++; if (pc_o !== '0) begin n_bad++; $display("FAIL reset[%0d] pc_o: got %h want 0", i, pc_o); end
      n_cmp++; if (instr_o !== '0) begin n_bad++; $display("FAIL reset[%0d] instr_o: got %h want 0", i, instr_o); end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_pairing();
    stim_t c; logic [1:0] ev; ent_t e0, e1; logic er;
    add(1, 'h10, 0, 0); add(1, 'h11, 0, 0); add(1, 'h12, 0, 0);
    add(0, 0, 2, 0); add(0, 0, 0, 0); add(0, 0, 1, 0);
    add(1, 'h20, 0, 0); add(1, 'h40, 0, 0); add(0, 0, 0, 0); add(0, 0, 1, 0);
    add(0, 0, 0, 0); add(0, 0, 1, 0);
    add(1, 'h3fffff, 0, 0); add(1, 'h0, 0, 0); add(0, 0, 2, 0); add(0, 0, 0, 0);
    for (int i = 0; stim_q.size() != 0; i++) begin
      c = stim_q.pop_front();
      drive(c); #1;
      model_expect(c, ev, e0, e1, er);
      n_cmp++; if ({v_o, ready_o} !== {ev, er}) begin n_bad++; $display("FAIL pairing[%0d] v_o/ready_o: got %b/%b want %b/%b", i, v_o, ready_o, ev, er); end
      n_cmp++; if ({pc_o, instr_o} !== {e1.pc, e0.pc, e1.instr, e0.instr}) begin n_bad++; $display("FAIL pairing[%0d] slots: got pc %h/%h instr %h/%h want pc %h/%h instr %h/%h", i, pc_o[0], pc_o[1], instr_o[0], instr_o[1], e0.pc, e1.pc, e0.instr, e1.instr); end
      advance(c);
    end
  endtask

  task automatic test_full_wrap();
    stim_t c; logic [1:0] ev; ent_t e0, e1; logic er;
    add(1, 'h50, 0, 0); add(1, 'h51, 0, 0); add(1, 'h52, 0, 0); add(1, 'h53, 0, 0);
    add(0, 0, 0, 0); add(1, 'h54, 1, 0); add(1, 'h54, 2, 0); add(1, 'h55, 1, 0);
    add(1, 'h56, 0, 0); add(1, 'h57, 2, 0); add(0, 0, 2, 0); add(0, 0, 0, 0);
    for (int i = 0; stim_q.size() != 0; i++) begin
      c = stim_q.pop_front();
      drive(c); #1;
      model_expect(c, ev, e0, e1, er);
      n_cmp++; if ({v_o, ready_o} !== {ev, er}) begin n_bad++; $display("FAIL full_wrap[%0d] v_o/ready_o: got %b/%b want %b/%b", i, v_o, ready_o, ev, er); end
      n_cmp++; if ({pc_o, instr_o} !== {e1.pc, e0.pc, e1.instr, e0.instr}) begin n_bad++; $display("FAIL full_wrap[%0d] slots: got pc %h/%h want pc %h/%h", i, pc_o[0], pc_o[1], e0.pc, e1.pc); end
      advance(c);
    end
  endtask

  task automatic test_flush();
    stim_t c; logic [1:0] ev; ent_t e0, e1; logic er;
    add(1, 'h70, 0, 0); add(1, 'h71, 0, 0); add(1, 'h72, 0, 0);
    add(1, 'h73, 2, 1); add(0, 0, 0, 0); add(1, 'h80, 0, 0); add(0, 0, 1, 0); add(0, 0, 0, 0);
    for (int i = 0; stim_q.size() != 0; i++) begin
      c = stim_q.pop_front();
      drive(c); #1;
      model_expect(c, ev, e0, e1, er);
      n_cmp++; if ({v_o, ready_o} !== {ev, er}) begin n_bad++; $display("FAIL flush[%0d] v_o/ready_o: got %b/%b want %b/%b", i, v_o, ready_o, ev, er); end
      n_cmp++; if ({pc_o, instr_o} !== {e1.pc, e0.pc, e1.instr, e0.instr}) begin n_bad++; $display("FAIL flush[%0d] slots: got pc %h/%h want pc %h/%h", i, pc_o[0], pc_o[1], e0.pc, e1.pc); end
      advance(c);
    end
  endtask

  task automatic test_bypass();
    stim_t c; logic [1:0] ev; ent_t e0, e1; logic er;
    add(1, 'h30, byp_lp ? 2'd1 : 2'd0, 0);
    add(0, 0, byp_lp ? 2'd0 : 2'd1, 0);
    add(0, 0, 0, 0);
    for (int i = 0; stim_q.size() != 0; i++) begin
      c = stim_q.pop_front();
      drive(c); #1;
      model_expect(c, ev, e0, e1, er);
      n_cmp++; if ({v_o, ready_o} !== {ev, er}) begin n_bad++; $display("FAIL bypass[%0d] v_o/ready_o: got %b/%b want %b/%b", i, v_o, ready_o, ev, er); end
      n_cmp++; if ({pc_o, instr_o} !== {e1.pc, e0.pc, e1.instr, e0.instr}) begin n_bad++; $display("FAIL bypass[%0d] slots: got pc %h/%h want pc %h/%h", i, pc_o[0], pc_o[1], e0.pc, e1.pc); end
      advance(c);
    end
  endtask

  task automatic test_back_to_back();
    stim_t c; logic [1:0] ev; ent_t e0, e1; logic er;
    add(1, 'h90, 0, 0);
    for (int k = 1; k < 8; k++) add(1, 22'h90 + 22'(k), 1, 0);
    add(0, 0, 1, 0); add(0, 0, 0, 0);
    for (int i = 0; stim_q.size() != 0; i++) begin
      c = stim_q.pop_front();
      drive(c); #1;
      model_expect(c, ev, e0, e1, er);
      n_cmp++; if ({v_o, ready_o} !== {ev, er}) begin n_bad++; $display("FAIL back_to_back[%0d] v_o/ready_o: got %b/%b want %b/%b", i, v_o, ready_o, ev, er); end
      n_cmp++; if ({pc_o, instr_o} !== {e1.pc, e0.pc, e1.instr, e0.instr}) begin n_bad++; $display("FAIL back_to_back[%0d] slots: got pc %h/%h want pc %h/%h", i, pc_o[0], pc_o[1], e0.pc, e1.pc); end
      advance(c);
    end
  endtask

  task automatic test_random();
    stim_t c; logic [1:0] ev; ent_t e0, e1; logic er;
    logic [pcw_lp-1:0] last_pc;
    last_pc = 22'h100;
    for (int i = 0; i < 400; i++) begin
      c.fl  = ($urandom_range(0, 19) == 0);
      c.v   = ($urandom_range(0, 2) != 0);
      c.pc  = ($urandom_range(0, 3) != 0) ? last_pc + 22'd1 : 22'($urandom);
      c.deq = 2'd0;
      model_expect(c, ev, e0, e1, er);
      c.deq = 2'($urandom_range(0, ev[1] ? 2 : (ev[0] ? 1 : 0)));
      if (!er && c.deq == 2'd0 && !c.fl) c.v = 1'b0;
      if (c.v) last_pc = c.pc;
      drive(c); #1;
      model_expect(c, ev, e0, e1, er);
      n_cmp++; if ({v_o, ready_o} !== {ev, er}) begin n_bad++; $display("FAIL random[%0d] v_o/ready_o: got %b/%b want %b/%b", i, v_o, ready_o, ev, er); end
      n_cmp++; if ({pc_o, instr_o} !== {e1.pc, e0.pc, e1.instr, e0.instr}) begin n_bad++; $display("FAIL random[%0d] slots: got pc %h/%h want pc %h/%h", i, pc_o[0], pc_o[1], e0.pc, e1.pc); end
      advance(c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pairing();
    test_full_wrap();
    test_flush();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
